// File: rtl/lock_chamber_if.sv
// Purpose: operator/board-side bundle for the lock chamber controller.
//   master : board top (drives switches/keys, observes lights/status)
//   slave  : lock_chamber_ctrl
// Signals:
//   dir, arr_sw, dep_sw, gate_lo_sw, gate_hi_sw, w_up, w_down    master -> slave
//   arr_li, dep_li, gate_lo_li, gate_hi_li, level, busy, fault,
//   pass_cnt                                                     slave -> master
interface lock_chamber_if #(
    parameter int unsigned LEVEL_W = 8,
    parameter int unsigned CNT_W   = 8
);
    logic               dir;
    logic               arr_sw;
    logic               dep_sw;
    logic               gate_lo_sw;
    logic               gate_hi_sw;
    logic               w_up;
    logic               w_down;
    logic               arr_li;
    logic               dep_li;
    logic               gate_lo_li;
    logic               gate_hi_li;
    logic [LEVEL_W-1:0] level;
    logic               busy;
    logic               fault;
    logic [CNT_W-1:0]   pass_cnt;

    modport master (
        output dir, arr_sw, dep_sw, gate_lo_sw, gate_hi_sw, w_up, w_down,
        input  arr_li, dep_li, gate_lo_li, gate_hi_li, level, busy, fault, pass_cnt
    );

    modport slave (
        input  dir, arr_sw, dep_sw, gate_lo_sw, gate_hi_sw, w_up, w_down,
        output arr_li, dep_li, gate_lo_li, gate_hi_li, level, busy, fault, pass_cnt
    );
endinterface

// File: rtl/lock_chamber_ctrl.sv
// Purpose: single-chamber canal-lock controller with bidirectional transit,
//   saturating water-level pumps, gate/level interlocks, gate-open watchdog
//   and a wrapping passage counter. All outputs are registered.
// Ports:
//   clk    clock (divided tick)
//   reset  asynchronous active-low reset
//   bus    lock_chamber_if.slave (switch inputs, light/status outputs)
module lock_chamber_ctrl #(
    parameter int unsigned LEVEL_W      = 8,
    parameter int unsigned LOW_LEVEL    = 0,
    parameter int unsigned HIGH_LEVEL   = 200,
    parameter int unsigned FILL_STEP    = 8,
    parameter int unsigned DRAIN_STEP   = 8,
    parameter int unsigned GATE_TIMEOUT = 64,
    parameter int unsigned CNT_W        = 8
) (
    input  logic          clk,
    input  logic          reset,
    lock_chamber_if.slave bus
);

    localparam int unsigned LW1  = LEVEL_W + 1;
    localparam int unsigned WD_W = $clog2(GATE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        ADJUST = 2'd2,
        EXIT   = 2'd3
    } state_t;

    state_t             r_state, w_state_next;
    logic               r_dir_q, w_dir_next;
    logic [LEVEL_W-1:0] r_level, w_level_next;
    logic [WD_W-1:0]    r_wd, w_wd_next;
    logic               r_fault, w_fault_next;
    logic [CNT_W-1:0]   r_pass_cnt, w_pass_cnt_next;
    logic               r_arr_li, w_arr_li_next;
    logic               r_dep_li, w_dep_li_next;
    logic               r_gate_lo_li, w_gate_lo_li_next;
    logic               r_gate_hi_li, w_gate_hi_li_next;
    logic               r_busy, w_busy_next;

    // Side selection: live dir while idle (decides the entry), latched dir otherwise
    logic               w_dir_sel;
    logic               w_entry_sw, w_exit_sw;
    logic [LEVEL_W-1:0] w_entry_lvl, w_exit_lvl;
    logic [LW1-1:0]     w_lvl_ext, w_fill_sum;
    logic               w_gate_cur, w_gate_nxt;

    assign w_dir_sel   = (r_state == IDLE) ? bus.dir : r_dir_q;
    assign w_entry_sw  = w_dir_sel ? bus.gate_hi_sw : bus.gate_lo_sw;
    assign w_exit_sw   = w_dir_sel ? bus.gate_lo_sw : bus.gate_hi_sw;
    assign w_entry_lvl = w_dir_sel ? LEVEL_W'(HIGH_LEVEL) : LEVEL_W'(LOW_LEVEL);
    assign w_exit_lvl  = w_dir_sel ? LEVEL_W'(LOW_LEVEL)  : LEVEL_W'(HIGH_LEVEL);
    assign w_lvl_ext   = {1'b0, r_level};
    assign w_fill_sum  = w_lvl_ext + LW1'(FILL_STEP);
    assign w_gate_cur  = (r_state == ENTRY) || (r_state == EXIT);
    assign w_gate_nxt  = (w_state_next == ENTRY) || (w_state_next == EXIT);

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_dir_q      <= 1'b0;
            r_level      <= LEVEL_W'(LOW_LEVEL);
            r_wd         <= '0;
            r_fault      <= 1'b0;
            r_pass_cnt   <= '0;
            r_arr_li     <= 1'b0;
            r_dep_li     <= 1'b0;
            r_gate_lo_li <= 1'b0;
            r_gate_hi_li <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_dir_q      <= w_dir_next;
            r_level      <= w_level_next;
            r_wd         <= w_wd_next;
            r_fault      <= w_fault_next;
            r_pass_cnt   <= w_pass_cnt_next;
            r_arr_li     <= w_arr_li_next;
            r_dep_li     <= w_dep_li_next;
            r_gate_lo_li <= w_gate_lo_li_next;
            r_gate_hi_li <= w_gate_hi_li_next;
            r_busy       <= w_busy_next;
        end
    end

    // Next state, pumps, watchdog and next-cycle outputs
    always_comb begin
        w_state_next      = r_state;
        w_dir_next        = r_dir_q;
        w_level_next      = r_level;
        w_wd_next         = r_wd;
        w_fault_next      = r_fault;
        w_pass_cnt_next   = r_pass_cnt;
        w_arr_li_next     = 1'b0;
        w_dep_li_next     = 1'b0;
        w_gate_lo_li_next = 1'b0;
        w_gate_hi_li_next = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.arr_sw && (r_level == w_entry_lvl) && w_entry_sw) begin
                    w_state_next = ENTRY;
                    w_dir_next   = bus.dir;
                end
            end
            ENTRY: begin
                if (!w_entry_sw) w_state_next = ADJUST;
            end
            ADJUST: begin
                if ((r_level == w_exit_lvl) && w_exit_sw) w_state_next = EXIT;
            end
            EXIT: begin
                if (bus.dep_sw && !w_exit_sw) begin
                    w_state_next    = IDLE;
                    w_pass_cnt_next = r_pass_cnt + CNT_W'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase

        // Pumps only with all gates closed; arithmetic one bit wider so it cannot wrap
        if ((r_state == IDLE) || (r_state == ADJUST)) begin
            if (bus.w_up && !bus.w_down) begin
                if (w_fill_sum > LW1'(HIGH_LEVEL)) w_level_next = LEVEL_W'(HIGH_LEVEL);
                else                               w_level_next = w_fill_sum[LEVEL_W-1:0];
            end else if (bus.w_down && !bus.w_up) begin
                if (w_lvl_ext < (LW1'(LOW_LEVEL) + LW1'(DRAIN_STEP)))
                    w_level_next = LEVEL_W'(LOW_LEVEL);
                else
                    w_level_next = r_level - LEVEL_W'(DRAIN_STEP);
            end
        end

        // Watchdog counts cycles spent with a gate open; saturates, fault is sticky
        if (w_gate_nxt && !w_gate_cur) begin
            w_wd_next = '0;
        end else if (w_gate_cur) begin
            if (32'(r_wd) < GATE_TIMEOUT) w_wd_next = r_wd + WD_W'(1);
            if ((32'(r_wd) + 32'd1) >= GATE_TIMEOUT) w_fault_next = 1'b1;
        end

        // Lights reflect the state being entered, gate side from the latched direction
        case (w_state_next)
            IDLE:  w_arr_li_next = bus.arr_sw;
            ENTRY: begin
                w_arr_li_next     = 1'b1;
                w_gate_hi_li_next = w_dir_next;
                w_gate_lo_li_next = !w_dir_next;
            end
            EXIT: begin
                w_dep_li_next     = 1'b1;
                w_gate_hi_li_next = !w_dir_next;
                w_gate_lo_li_next = w_dir_next;
            end
            default: ;
        endcase

        w_busy_next = (w_state_next != IDLE);
    end

    assign bus.arr_li     = r_arr_li;
    assign bus.dep_li     = r_dep_li;
    assign bus.gate_lo_li = r_gate_lo_li;
    assign bus.gate_hi_li = r_gate_hi_li;
    assign bus.level      = r_level;
    assign bus.busy       = r_busy;
    assign bus.fault      = r_fault;
    assign bus.pass_cnt   = r_pass_cnt;

endmodule

// File: tb/tb_lock_chamber_ctrl.sv
// Purpose: directed self-checking bench for lock_chamber_ctrl.
module tb_lock_chamber_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    lock_chamber_if #(.LEVEL_W(8), .CNT_W(8)) bus ();

    lock_chamber_ctrl #(
        .LEVEL_W(8), .LOW_LEVEL(0), .HIGH_LEVEL(200), .FILL_STEP(8),
        .DRAIN_STEP(8), .GATE_TIMEOUT(64), .CNT_W(8)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_lights(input string tag, input int unsigned arr, input int unsigned dep,
                                input int unsigned glo, input int unsigned ghi, input int unsigned bsy);
        check_eq({tag, ".arr_li"},     32'(bus.arr_li),     arr);
        check_eq({tag, ".dep_li"},     32'(bus.dep_li),     dep);
        check_eq({tag, ".gate_lo_li"}, 32'(bus.gate_lo_li), glo);
        check_eq({tag, ".gate_hi_li"}, 32'(bus.gate_hi_li), ghi);
        check_eq({tag, ".busy"},       32'(bus.busy),       bsy);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned exp_lvl;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.dir = 1'b0; bus.arr_sw = 1'b0; bus.dep_sw = 1'b0;
        bus.gate_lo_sw = 1'b0; bus.gate_hi_sw = 1'b0;
        bus.w_up = 1'b0; bus.w_down = 1'b0;
        tick(3);
        check_lights("rst", 0, 0, 0, 0, 0);
        check_eq("rst.level", 32'(bus.level), 0);
        check_eq("rst.fault", 32'(bus.fault), 0);
        check_eq("rst.pass_cnt", 32'(bus.pass_cnt), 0);
        rst_n = 1'b1;
        tick();

        // Low->high entry
        bus.arr_sw = 1'b1; bus.gate_lo_sw = 1'b1;
        tick();
        check_lights("t1.entry", 1, 0, 1, 0, 1);
        check_eq("t1.level", 32'(bus.level), 0);

        // Pumps disabled while a gate is open
        bus.w_up = 1'b1;
        tick(3);
        bus.w_up = 1'b0;
        check_eq("t4.entry_pump", 32'(bus.level), 0);

        bus.gate_lo_sw = 1'b0; bus.arr_sw = 1'b0;
        tick();
        check_lights("t1.adjust", 0, 0, 0, 0, 1);

        // Exit request without level match is ignored
        bus.gate_hi_sw = 1'b1;
        tick();
        check_lights("t2.nomatch", 0, 0, 0, 0, 1);
        bus.gate_hi_sw = 1'b0;

        // Fill with saturation at 200
        bus.w_up = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            exp_lvl = (8 * i > 200) ? 200 : 8 * i;
            check_eq($sformatf("t2.fill%0d", i), 32'(bus.level), exp_lvl);
        end
        bus.w_up = 1'b0;

        bus.gate_hi_sw = 1'b1;
        tick();
        check_lights("t2.exit", 0, 1, 0, 1, 1);

        bus.w_down = 1'b1;
        tick(2);
        bus.w_down = 1'b0;
        check_eq("t4.exit_pump", 32'(bus.level), 200);

        // Departure needs the gate released as well
        bus.dep_sw = 1'b1;
        tick();
        check_lights("t2.gate_held", 0, 1, 0, 1, 1);
        bus.gate_hi_sw = 1'b0;
        tick();
        check_lights("t2.idle", 0, 0, 0, 0, 0);
        check_eq("t2.pass_cnt", 32'(bus.pass_cnt), 1);
        bus.dep_sw = 1'b0;

        // Drain in IDLE, then both pumps held
        bus.w_down = 1'b1;
        tick(25);
        bus.w_down = 1'b0;
        check_eq("t3.drain_idle", 32'(bus.level), 0);
        bus.w_up = 1'b1; bus.w_down = 1'b1;
        tick(10);
        bus.w_up = 1'b0; bus.w_down = 1'b0;
        check_eq("t4.both_pumps", 32'(bus.level), 0);

        // High->low: request at wrong level is ignored
        bus.dir = 1'b1; bus.arr_sw = 1'b1; bus.gate_hi_sw = 1'b1;
        tick();
        check_lights("t3.wrong_lvl", 1, 0, 0, 0, 0);
        bus.w_up = 1'b1;
        tick(25);
        check_eq("t3.fill_idle", 32'(bus.level), 200);
        check_eq("t3.still_idle", 32'(bus.busy), 0);
        tick();
        bus.w_up = 1'b0;
        check_lights("t3.entry_hi", 1, 0, 0, 1, 1);

        // dir flip after entry must not move the gate side
        bus.dir = 1'b0;
        bus.gate_hi_sw = 1'b0; bus.arr_sw = 1'b0;
        tick();
        check_lights("t3.adjust", 0, 0, 0, 0, 1);
        bus.w_down = 1'b1;
        tick(25);
        bus.w_down = 1'b0;
        check_eq("t3.drain_adj", 32'(bus.level), 0);
        bus.gate_lo_sw = 1'b1;
        tick();
        check_lights("t3.exit_lo", 0, 1, 1, 0, 1);
        bus.dep_sw = 1'b1; bus.gate_lo_sw = 1'b0;
        tick();
        bus.dep_sw = 1'b0;
        check_lights("t3.idle", 0, 0, 0, 0, 0);
        check_eq("t3.pass_cnt", 32'(bus.pass_cnt), 2);

        // Watchdog: 64 cycles in ENTRY raises a sticky fault
        bus.dir = 1'b0; bus.arr_sw = 1'b1; bus.gate_lo_sw = 1'b1;
        tick();
        check_lights("t5.entry", 1, 0, 1, 0, 1);
        check_eq("t5.fault_start", 32'(bus.fault), 0);
        tick(63);
        check_eq("t5.fault_63", 32'(bus.fault), 0);
        tick();
        check_eq("t5.fault_64", 32'(bus.fault), 1);
        bus.gate_lo_sw = 1'b0; bus.arr_sw = 1'b0;
        tick();
        check_lights("t5.adjust", 0, 0, 0, 0, 1);
        check_eq("t5.fault_sticky", 32'(bus.fault), 1);

        // Async reset mid-ADJUST at level 96
        bus.w_up = 1'b1;
        tick(12);
        bus.w_up = 1'b0;
        check_eq("t6.level96", 32'(bus.level), 96);
        rst_n = 1'b0;
        #1;
        check_lights("t6.rst", 0, 0, 0, 0, 0);
        check_eq("t6.level", 32'(bus.level), 0);
        check_eq("t6.fault", 32'(bus.fault), 0);
        check_eq("t6.pass_cnt", 32'(bus.pass_cnt), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
